// File: rtl/mem_arbiter.sv
// Two-to-one arbiter merging I-cache and D-cache line requests onto one memory port.
// Define MEM_ARB_FIXED_PRIO_EN to give the I-cache fixed priority instead of round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   i_req_s, d_req_s;

  assign i_req_s     = i_mem_read;
  assign d_req_s     = d_mem_read | d_mem_write;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

  // Arbitration state register
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  // last_d_q is 1 when the most recent grant went to D; reset means I was last
  logic last_d_q, last_d_d;

  // Round-robin history register
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end

  // Record the side granted on each IDLE exit
  always_comb begin
    last_d_d = last_d_q;
    if ((state_q == IDLE) && (state_d != IDLE)) begin
      last_d_d = (state_d == GRANT_D);
    end else begin
      last_d_d = last_d_q;
    end
  end
`endif

  // Next-state: requests only sampled in IDLE, so a request still held in the ready cycle is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_req_s && d_req_s) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          state_d = GRANT_I;
`else
          state_d = last_d_q ? GRANT_I : GRANT_D;
`endif
        end else if (i_req_s) begin
          state_d = GRANT_I;
        end else if (d_req_s) begin
          state_d = GRANT_D;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs follow the granted requester's live inputs
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (state_q)
      IDLE: begin
        mem_read = 1'b0;
      end
      GRANT_I: begin
        mem_read    = i_mem_read;
        mem_addr    = i_mem_addr;
        i_mem_ready = mem_ready;
      end
      GRANT_D: begin
        // simultaneous read and write is illegal; the write takes precedence
        mem_read    = d_mem_read & ~d_mem_write;
        mem_write   = d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand sequences, and
// randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_rd, d_rd, d_wr, m_rdy;
  logic [29:0]  i_addr, d_addr;
  logic [127:0] d_wdata, m_rdata;
  logic [127:0] i_rdata, d_rdata, m_wdata;
  logic         i_rdy, d_rdy, m_rd, m_wr;
  logic [29:0]  m_addr;

  int errors = 0;
  int checks = 0;

  // reference model: who owns the memory port (0 none, 1 I, 2 D) and whether D wins the next tie
  int m_owner;
  bit m_prefer_d;

  mem_arbiter dut (
    .clk(clk), .proc_reset_n(rst_n),
    .i_mem_read(i_rd), .i_mem_addr(i_addr), .i_mem_rdata(i_rdata), .i_mem_ready(i_rdy),
    .d_mem_read(d_rd), .d_mem_write(d_wr), .d_mem_addr(d_addr), .d_mem_wdata(d_wdata),
    .d_mem_rdata(d_rdata), .d_mem_ready(d_rdy),
    .mem_read(m_rd), .mem_write(m_wr), .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_rdata(m_rdata), .mem_ready(m_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ir, dr, dw, mr;
    logic [29:0] ia, da;
    logic [33:0] exp;  // {mem_read, mem_write, mem_addr, i_ready, d_ready}
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t v(input logic ir, dr, dw, mr, input logic [29:0] ia, da,
                             input logic er, ew, input logic [29:0] ea, input logic eir, edr);
    vec_t r;
    r.ir = ir; r.dr = dr; r.dw = dw; r.mr = mr; r.ia = ia; r.da = da;
    r.exp = {er, ew, ea, eir, edr};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_prefer_d = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {i_rd, d_rd, d_wr, m_rdy} = 4'b0000;
    i_addr = 30'h0; d_addr = 30'h0; d_wdata = 128'h0; m_rdata = 128'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("reset_outputs", {m_rd, m_wr, m_addr, m_wdata, i_rdy, d_rdy},
        {1'b0, 1'b0, 30'h0, 128'h0, 1'b0, 1'b0});
  endtask

  // drive one cycle, compare against the model, then advance the model past the next edge
  task automatic cyc(input logic ir, dr, dw, mr, input logic [29:0] ia, da,
                     input logic [127:0] wd, rd);
    logic er, ew, eir, edr;
    logic [29:0] ea;
    logic [127:0] ewd;
    @(negedge clk);
    i_rd = ir; d_rd = dr; d_wr = dw; m_rdy = mr;
    i_addr = ia; d_addr = da; d_wdata = wd; m_rdata = rd;
    #1;
    er = 1'b0; ew = 1'b0; eir = 1'b0; edr = 1'b0; ea = 30'h0; ewd = 128'h0;
    if (m_owner == 1) begin
      er = ir; ea = ia; eir = mr;
    end else if (m_owner == 2) begin
      ew = dw; er = dr & ~dw; ea = da; ewd = wd; edr = mr;
    end
    chk("model_bus", {m_rd, m_wr, m_addr, i_rdy, d_rdy}, {er, ew, ea, eir, edr});
    chk("model_wdata", m_wdata, ewd);
    chk("model_rdata", {i_rdata, d_rdata}, {rd, rd});
    if (m_owner != 0) begin
      if (mr) m_owner = 0;
    end else if (ir || dr || dw) begin
      if (ir && (dr || dw)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        m_owner = 1;
`else
        m_owner = m_prefer_d ? 2 : 1;
`endif
      end else begin
        m_owner = ir ? 1 : 2;
      end
      m_prefer_d = (m_owner == 1);
    end
  endtask

  initial begin
    int ipulses, dpulses;
    logic ir, dr, dw;
    tbl[0]  = v(1,0,1,0, 30'h10,30'h20, 0,0,30'h0 ,0,0);
`ifdef MEM_ARB_FIXED_PRIO_EN
    tbl[1]  = v(1,0,1,0, 30'h10,30'h20, 1,0,30'h10,0,0);
    tbl[2]  = v(1,0,1,1, 30'h10,30'h20, 1,0,30'h10,1,0);
    tbl[3]  = v(0,0,1,0, 30'h10,30'h20, 0,0,30'h0 ,0,0);
    tbl[4]  = v(0,0,1,0, 30'h10,30'h20, 0,1,30'h20,0,0);
    tbl[5]  = v(0,0,1,1, 30'h10,30'h20, 0,1,30'h20,0,1);
`else
    tbl[1]  = v(1,0,1,0, 30'h10,30'h20, 0,1,30'h20,0,0);
    tbl[2]  = v(1,0,1,1, 30'h10,30'h20, 0,1,30'h20,0,1);
    tbl[3]  = v(1,0,0,0, 30'h10,30'h20, 0,0,30'h0 ,0,0);
    tbl[4]  = v(1,0,0,0, 30'h10,30'h20, 1,0,30'h10,0,0);
    tbl[5]  = v(1,0,0,1, 30'h10,30'h20, 1,0,30'h10,1,0);
`endif
    tbl[6]  = v(0,0,0,0, 30'h10,30'h20, 0,0,30'h0 ,0,0);
    tbl[7]  = v(0,0,1,0, 30'h10,30'h40, 0,0,30'h0 ,0,0);
    tbl[8]  = v(0,0,1,0, 30'h10,30'h40, 0,1,30'h40,0,0);
    tbl[9]  = v(0,0,1,1, 30'h10,30'h40, 0,1,30'h40,0,1);
    tbl[10] = v(1,1,0,0, 30'h10,30'h80, 0,0,30'h0 ,0,0);
    tbl[11] = v(1,1,0,0, 30'h10,30'h80, 1,0,30'h10,0,0);
    tbl[12] = v(1,1,0,1, 30'h10,30'h80, 1,0,30'h10,1,0);
    tbl[13] = v(0,1,0,0, 30'h10,30'h80, 0,0,30'h0 ,0,0);
    tbl[14] = v(0,1,0,0, 30'h10,30'h80, 1,0,30'h80,0,0);
    tbl[15] = v(0,1,0,1, 30'h10,30'h80, 1,0,30'h80,0,1);
    tbl[16] = v(0,0,0,1, 30'h10,30'h80, 0,0,30'h0 ,0,0);
    tbl[17] = v(0,0,0,0, 30'h10,30'h80, 0,0,30'h0 ,0,0);
    tbl[18] = v(0,1,1,0, 30'h10,30'h55, 0,0,30'h0 ,0,0);
    tbl[19] = v(0,1,1,0, 30'h10,30'h55, 0,1,30'h55,0,0);
    tbl[20] = v(0,1,1,1, 30'h10,30'h55, 0,1,30'h55,0,1);
    tbl[21] = v(0,0,0,0, 30'h10,30'h55, 0,0,30'h0 ,0,0);

    do_reset();
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      i_rd = tbl[k].ir; d_rd = tbl[k].dr; d_wr = tbl[k].dw; m_rdy = tbl[k].mr;
      i_addr = tbl[k].ia; d_addr = tbl[k].da;
      #1;
      chk($sformatf("vec%0d", k), {m_rd, m_wr, m_addr, i_rdy, d_rdy}, tbl[k].exp);
    end

    // lone I refill with memory answering on the fourth granted cycle
    do_reset();
    ipulses = 0; dpulses = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(k < 5, 1'b0, 1'b0, k == 4, 30'h104, 30'h0, 128'h0,
          (k == 4) ? 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0004 : 128'h0);
      if (k == 1) chk("refill_read_latency", {m_rd, m_addr}, {1'b1, 30'h104});
      if (k == 4) chk("refill_rdata", i_rdata, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0004);
      ipulses += int'(i_rdy);
      dpulses += int'(d_rdy);
    end
    chk("refill_i_pulses", ipulses, 1);
    chk("refill_d_pulses", dpulses, 0);

    // randomized traffic with sticky requests
    do_reset();
    ir = 1'b0; dr = 1'b0; dw = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) ir = ~ir;
      if ($urandom_range(0, 3) == 0) dr = ~dr;
      if ($urandom_range(0, 5) == 0) dw = ~dw;
      cyc(ir, dr, dw, $urandom_range(0, 3) == 0,
          30'($urandom), 30'($urandom),
          {$urandom, $urandom, $urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom});
    end

    // reset asserted in the middle of a D write-back
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 30'h77, 128'h5A, 128'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 30'h77, 128'h5A, 128'h0);
    chk("pre_reset_write", m_wr, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_write", {m_wr, m_rd, m_addr, m_wdata}, {1'b0, 1'b0, 30'h0, 128'h0});
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-to-one memory arbiter that sits directly downstream of the instruction cache and the data cache.
- Merges their 128-bit line-refill and write-back requests onto the single shared memory port.
- Owns all contention handling, so each cache behaves as if it had a private memory.
- One transaction is in flight at a time; the grant is held until memory returns ready.

Parameters:
ADDR_W, 30, word address width of cache and memory ports
DATA_W, 128, cache line width

Ports:
clk  in  1  system clock
proc_reset_n  in  1  asynchronous active-low reset
i_mem_read  in  1  I-cache refill request
i_mem_addr  in  ADDR_W  I-cache request address
i_mem_rdata  out  DATA_W  line returned to I-cache
i_mem_ready  out  1  completion pulse to I-cache
d_mem_read  in  1  D-cache refill request
d_mem_write  in  1  D-cache write-back request
d_mem_addr  in  ADDR_W  D-cache request address
d_mem_wdata  in  DATA_W  D-cache write-back line
d_mem_rdata  out  DATA_W  line returned to D-cache
d_mem_ready  out  1  completion pulse to D-cache
mem_read  out  1  read request to memory
mem_write  out  1  write request to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write line
mem_rdata  in  DATA_W  memory read line
mem_ready  in  1  memory completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset proc_reset_n is asynchronous, active-low.
- Reset values: state=IDLE, last_grant=I (so D wins the first conflict); mem_read/mem_write/i_mem_ready/d_mem_ready=0; mem_addr/mem_wdata=0.
- Request definitions:
  - I request = i_mem_read.
  - D request = d_mem_read | d_mem_write.
  - Requesters hold request, address and wdata stable until they see ready; the arbiter does not latch them.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - Drives all mem_* outputs 0.
  - Samples requests at the clock edge.
  - Only I pending → GRANT_I. Only D pending → GRANT_D. Neither pending → stay in IDLE.
  - Both pending → round-robin: grant the side not in last_grant.
  - On every grant, last_grant := granted side.
- GRANT_I:
  - mem_read=i_mem_read, mem_write=0, mem_addr=i_mem_addr, mem_wdata=0.
- GRANT_D:
  - mem_read=d_mem_read, mem_write=d_mem_write, mem_addr=d_mem_addr, mem_wdata=d_mem_wdata.
  - If d_mem_read and d_mem_write are both high (illegal), mem_write is driven and mem_read is forced 0.
- Ready routing:
  - In a GRANT state, mem_ready is routed combinationally to the granted side's ready; the other side's ready stays 0.
  - mem_rdata is broadcast combinationally to both i_mem_rdata and d_mem_rdata in all states.
- Completion: mem_ready high in GRANT_x → IDLE on the next edge.
  - The requester's still-asserted request during the ready cycle is not a new request.
  - A request present in the cycle after the ready cycle is sampled normally, so D write-back followed by refill works back-to-back.
- Latency: one cycle from request assertion to mem_read/mem_write assertion. Minimum turnaround is ready cycle plus one IDLE cycle.
- mem_ready while in IDLE: ignored; no ready is forwarded.
- Granted request dropped before ready (protocol violation): outputs follow the live inputs, i.e. fall to 0; the state remains GRANT_x until mem_ready.
- Reset asserted mid-transaction: state and outputs return to reset values immediately; the in-flight memory access is abandoned.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: on a conflict in IDLE the I-cache always wins; last_grant is not implemented.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold proc_reset_n=0 for 3 cycles, then release → all outputs 0 and state IDLE; assert reset mid-GRANT_D → mem_write falls to 0 without waiting for a clock edge.
- Lone I refill: i_mem_read=1, i_mem_addr=30'h0000_0104, memory ready after 4 cycles with mem_rdata=128'hDEAD…0004 → mem_read high from cycle+1; i_mem_ready is a one-cycle pulse with i_mem_rdata equal to mem_rdata; d_mem_ready stays 0 throughout.
- Simultaneous I read of 30'h10 and D write of 30'h20 after reset → D granted first with mem_write=1 and mem_addr=30'h20; after its ready, I is granted with mem_addr=30'h10; with MEM_ARB_FIXED_PRIO_EN defined the order is reversed.
- Back-to-back D write-back then refill: D write of 30'h40 completes; next cycle D read of 30'h80 while I is also pending → I granted (round-robin); D served after I's ready.
- Stray mem_ready pulse in IDLE → neither i_mem_ready nor d_mem_ready asserts and the state stays IDLE.
- Illegal d_mem_read=d_mem_write=1 → mem_write=1 and mem_read=0 while in GRANT_D.
